hit_frame_serializer: RTL and testbench

Multi-channel successor to the 8-bit inverting load-and-shift register in the signal-acquisition FPGA. It accumulates scintillator hit flags per channel into sticky latches while armed. On request, it snapshots them into a framed serial word (header, channel bits, optional parity) and shifts the word out MSB-first. Handshake outputs let the readout controller sequence frames without losing hits that arrive during capture.

---
 rtl/hit_frame_serializer.sv | 118 +++++++++++
 tb/tb_hit_frame_serializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hit_frame_serializer.sv
// Sticky per-channel hit latches snapshotted into a framed serial word.
// Optional trailing even-parity bit enabled by defining PARITY_EN.
module hit_frame_serializer #(
    parameter int              N_CH    = 16,
    parameter int              HDR_W   = 4,
    parameter logic [HDR_W-1:0] HDR_VAL = 4'b1010,
    parameter bit              INVERT  = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] HIT,
    input  logic            ARM,
    input  logic            START,
    output logic            Q,
    output logic            BUSY,
    output logic            DONE
);

`ifdef PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int L  = HDR_W + N_CH + P;
    localparam int CW = $clog2(L + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [L-1:0]    shift_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [N_CH-1:0] latch_q;
    logic [N_CH-1:0] latch_d;
    logic [N_CH-1:0] hit_n;
    logic [L-1:0]    frame_d;
    logic            accept;

    assign hit_n  = INVERT ? ~HIT : HIT;
    // The DONE cycle may accept so a held START gives an L+1 cycle period.
    assign accept = START && (state_q != S_SHIFT);

`ifdef PARITY_EN
    assign frame_d = {HDR_VAL, latch_q, ^latch_q};
`else
    assign frame_d = {HDR_VAL, latch_q};
`endif

    // Next latch: snapshot restarts accumulation, otherwise sticky OR.
    always_comb begin
        latch_d = latch_q;
        if (accept) begin
            latch_d = ARM ? hit_n : '0;
        end else if (ARM) begin
            latch_d = latch_q | hit_n;
        end
    end

    // Hit latch register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            latch_q <= '0;
        end else begin
            latch_q <= latch_d;
        end
    end

    // Frame FSM with registered BUSY/DONE and the shift register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        shift_q <= frame_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    shift_q <= shift_q << 1;
                    if (cnt_q == CW'(L - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Q    = busy_q & shift_q[L-1];
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_hit_frame_serializer.sv
// Directed bench for hit_frame_serializer (N_CH=8, both polarities).
// Expected frame length follows PARITY_EN.
module tb_hit_frame_serializer;

`ifdef PARITY_EN
    localparam int L = 13;
`else
    localparam int L = 12;
`endif

    logic       CLK;
    logic       RST;
    logic       START;
    logic [7:0] HIT0;
    logic [7:0] HIT1;
    logic       ARM0;
    logic       ARM1;
    logic       Q0, BUSY0, DONE0;
    logic       Q1, BUSY1, DONE1;

    int n_chk;
    int n_pass;

    logic [12:0] f0;
    logic [12:0] f1;

    hit_frame_serializer #(
        .N_CH(8), .HDR_W(4), .HDR_VAL(4'b1010), .INVERT(1'b0)
    ) dut0 (
        .CLK(CLK), .RST(RST), .HIT(HIT0), .ARM(ARM0), .START(START),
        .Q(Q0), .BUSY(BUSY0), .DONE(DONE0)
    );

    hit_frame_serializer #(
        .N_CH(8), .HDR_W(4), .HDR_VAL(4'b1010), .INVERT(1'b1)
    ) dut1 (
        .CLK(CLK), .RST(RST), .HIT(HIT1), .ARM(ARM1), .START(START),
        .Q(Q1), .BUSY(BUSY1), .DONE(DONE1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Header 1010, channels MSB-first, then even parity when enabled.
    function automatic logic [12:0] exp_frame(input logic [7:0] v);
`ifdef PARITY_EN
        return {4'b1010, v, ^v};
`else
        return {1'b0, 4'b1010, v};
`endif
    endfunction

    task automatic pulse0(input logic [7:0] v);
        HIT0 = v;
        tick();
        HIT0 = 8'h00;
    endtask

    task automatic run_frame(input string tag, input int pulse_at,
                             input bit hold,
                             output logic [12:0] o0,
                             output logic [12:0] o1);
        int nb;
        o0 = '0;
        o1 = '0;
        nb = 0;
        START = 1'b1;
        tick();
        HIT0 = 8'h00;
        HIT1 = 8'hFF;
        if (!hold) START = 1'b0;
        for (int i = 0; i < L; i++) begin
            o0 = {o0[11:0], Q0};
            o1 = {o1[11:0], Q1};
            if (BUSY0) nb++;
            if (!hold) START = (i == pulse_at);
            tick();
        end
        if (!hold) START = 1'b0;
        chk({tag, ".busy_len"}, nb, L);
        chk({tag, ".done"}, DONE0, 1'b1);
        chk({tag, ".busy_off"}, BUSY0, 1'b0);
        chk({tag, ".q_off"}, Q0, 1'b0);
        tick();
        chk({tag, ".done_clr"}, DONE0, 1'b0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        RST    = 1'b1;
        START  = 1'b0;
        HIT0   = 8'h00;
        HIT1   = 8'hFF;
        ARM0   = 1'b1;
        ARM1   = 1'b1;
        tick();
        chk("rst.q", Q0, 1'b0);
        chk("rst.busy", BUSY0, 1'b0);
        chk("rst.done", DONE0, 1'b0);
        RST = 1'b0;
        tick();

        // Accumulate 05 then 80 -> latch 85.
        pulse0(8'h05);
        pulse0(8'h80);
        run_frame("basic", -1, 1'b0, f0, f1);
`ifdef PARITY_EN
        chk("basic.frame", f0, 13'b1010_10000101_1);
`else
        chk("basic.frame", f0, 13'b0_1010_10000101);
`endif

        // Hit on the accepting edge goes to the next frame.
        pulse0(8'h01);
        HIT0 = 8'h10;
        run_frame("acc1", -1, 1'b0, f0, f1);
        chk("acc1.frame", f0, exp_frame(8'h01));
        run_frame("acc2", -1, 1'b0, f0, f1);
        chk("acc2.frame", f0, exp_frame(8'h10));

        // START five cycles into a frame is ignored.
        pulse0(8'h3C);
        run_frame("ign", 5, 1'b0, f0, f1);
        chk("ign.frame", f0, exp_frame(8'h3C));
        tick();
        tick();
        chk("ign.no_frame", BUSY0, 1'b0);

        // Held START re-accepts on the edge that ends DONE.
        pulse0(8'h81);
        run_frame("hold", -1, 1'b1, f0, f1);
        chk("hold.frame", f0, exp_frame(8'h81));
        chk("hold.reaccept_busy", BUSY0, 1'b1);
        chk("hold.reaccept_q", Q0, 1'b1);
        START = 1'b0;
        repeat (L + 2) tick();
        chk("hold.drained", BUSY0, 1'b0);

        // Asynchronous reset in the middle of a frame.
        pulse0(8'hFF);
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (6) tick();
        chk("rst_mid.pre_q", Q0, 1'b1);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_mid.q", Q0, 1'b0);
        chk("rst_mid.busy", BUSY0, 1'b0);
        chk("rst_mid.done", DONE0, 1'b0);
        tick();
        RST = 1'b0;
        tick();
        run_frame("post_rst", -1, 1'b0, f0, f1);
        chk("post_rst.frame", f0, exp_frame(8'h00));

        // Active-low inputs; a pulse while disarmed is dropped.
        HIT1 = 8'hFB;
        tick();
        HIT1 = 8'hFF;
        ARM1 = 1'b0;
        HIT1 = 8'h7F;
        tick();
        HIT1 = 8'hFF;
        tick();
        run_frame("pol", -1, 1'b0, f0, f1);
`ifdef PARITY_EN
        chk("pol.frame", f1, 13'b1010_00000100_1);
`else
        chk("pol.frame", f1, 13'b0_1010_00000100);
`endif
        ARM1 = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
